ddr_rd_frame_ctrl: RTL and testbench

- Parametrised DDR-to-display read controller.
- Fetches one frame per display vsync from a selectable bank/channel region of DDR, in fixed-length bursts, into the display write FIFO.
- Adds over the previous generation:
  - an explicit burst state machine with beat counting;
  - a safe mid-burst resync on vsync (drain, discard, flush);
  - a late-frame status flag;
  - parametrised burst, frame, FIFO and channel geometry.
- Sits between the DDR read arbiter port and the 32-bit-write display FIFO.

---
 rtl/ddr_rd_pkg.sv | 27 ++
 rtl/vs_sync_edge.sv | 34 +++
 rtl/ddr_rd_frame_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ddr_rd_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_pkg.sv
// ============================================================================
// ddr_rd_pkg : shared types and geometry helpers for the DDR display reader
// Rev 1.0
// ============================================================================
`default_nettype none

package ddr_rd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_REQ   = 3'd2,
        S_DATA  = 3'd3,
        S_HOLD  = 3'd4,
        S_DRAIN = 3'd5
    } rd_state_t;

    localparam int RD_LEN_W = 10;

    // Address layout is {bank, 1'b0, channel, offset}.
    function automatic int rd_addr_w(input int bank_w, input int ch_w, input int offs_w);
        return bank_w + 1 + ch_w + offs_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vs_sync_edge.sv
// ============================================================================
// vs_sync_edge : 2-flop synchroniser with a one-cycle falling-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module vs_sync_edge (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic async_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign fall_o = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/ddr_rd_frame_ctrl.sv
// ============================================================================
// ddr_rd_frame_ctrl : per-vsync frame fetch from DDR into the display FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module ddr_rd_frame_ctrl
    import ddr_rd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BANK_W      = 2,
    parameter int CH_W        = 4,
    parameter int OFFS_W      = 18,
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 245760,
    parameter int FIFO_LEN_W  = 10,
    parameter int FIFO_THRESH = 750
) (
    input  logic                                       ddr_clk,
    input  logic                                       ddr_rstn,
    input  logic                                       ddr_ready,
    output logic                                       mem_ren,
    input  logic                                       mem_ren_valid,
    output logic [rd_addr_w(BANK_W, CH_W, OFFS_W)-1:0] rd_addr,
    output logic [RD_LEN_W-1:0]                        rd_len,
    input  logic                                       rd_burst_data_valid,
    input  logic [DATA_W-1:0]                          rd_burst_data,
    output logic                                       w_fifo_clk,
    output logic                                       w_fifo_en,
    output logic [DATA_W-1:0]                          w_fifo_data,
    input  logic [FIFO_LEN_W-1:0]                      fifo_len,
    input  logic                                       fifo_full,
    output logic                                       fifo_clearn,
    input  logic                                       bank_load,
    input  logic [BANK_W-1:0]                          bank_sel,
    input  logic [CH_W-1:0]                            ch_sel,
    input  logic                                       frame_wr_done,
    input  logic                                       vga_vs,
    output logic                                       frame_rd_done,
    output logic                                       rd_late,
    input  logic                                       rd_late_clr
);

    localparam int                    ADDR_W    = rd_addr_w(BANK_W, CH_W, OFFS_W);
    localparam int                    BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN);
    localparam logic [OFFS_W-1:0]     OFFS_STEP = OFFS_W'(BURST_LEN);
    localparam logic [OFFS_W-1:0]     OFFS_END  = OFFS_W'(FRAME_WORDS);
    localparam logic [FIFO_LEN_W-1:0] THRESH    = FIFO_LEN_W'(FIFO_THRESH);

    rd_state_t           state_q;
    logic [BANK_W-1:0]   bank_pend_q;
    logic [BANK_W-1:0]   bank_q;
    logic [CH_W-1:0]     ch_q;
    logic [OFFS_W-1:0]   offs_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                mem_ren_q;
    logic                fifo_clearn_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                done_q;
    logic                late_q;
    logic                first_q;
    logic                resync_q;

    logic                vs_fall;
    logic [BEAT_W-1:0]   beat_d;
    logic [OFFS_W-1:0]   offs_d;
    logic                beat_last;
    logic                frame_end;
    logic                can_req;
    logic [ADDR_W-1:0]   addr;

    vs_sync_edge u_vs_sync (
        .clk_i   (ddr_clk),
        .rstn_i  (ddr_rstn),
        .async_i (vga_vs),
        .fall_o  (vs_fall)
    );

    assign beat_d    = beat_q + BEAT_W'(1);
    assign offs_d    = offs_q + OFFS_STEP;
    assign beat_last = rd_burst_data_valid && (beat_d == BEAT_LAST);
    assign frame_end = (offs_q == OFFS_END);
    assign can_req   = (fifo_len < THRESH) && !fifo_full && ddr_ready;

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state_q       <= S_IDLE;
            bank_pend_q   <= '0;
            bank_q        <= '0;
            ch_q          <= '0;
            offs_q        <= '0;
            beat_q        <= '0;
            mem_ren_q     <= 1'b0;
            fifo_clearn_q <= 1'b1;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            done_q        <= 1'b0;
            late_q        <= 1'b0;
            first_q       <= 1'b0;
            resync_q      <= 1'b0;
        end else begin
            fifo_clearn_q <= 1'b1;
            wen_q         <= 1'b0;
            done_q        <= 1'b0;
            if (bank_load)     bank_pend_q <= bank_sel;
            if (frame_wr_done) first_q     <= 1'b1;
            // Placed before the state case so a same-cycle set overrides it.
            if (rd_late_clr)   late_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (first_q && ddr_ready && vs_fall) begin
                        state_q       <= S_ARM;
                        fifo_clearn_q <= 1'b0;
                    end
                end
                S_ARM: begin
                    bank_q   <= bank_pend_q;
                    ch_q     <= ch_sel;
                    offs_q   <= '0;
                    resync_q <= 1'b0;
                    state_q  <= S_REQ;
                end
                S_REQ: begin
                    if (vs_fall) late_q <= 1'b1;
                    if (!mem_ren_q) begin
                        if (vs_fall) begin
                            state_q       <= S_ARM;
                            fifo_clearn_q <= 1'b0;
                        end else if (can_req) begin
                            mem_ren_q <= 1'b1;
                        end
                    end else if (mem_ren_valid) begin
                        // An accepted burst must be consumed even if vsync came meanwhile.
                        mem_ren_q <= 1'b0;
                        beat_q    <= '0;
                        offs_q    <= offs_d;
                        state_q   <= (resync_q || vs_fall) ? S_DRAIN : S_DATA;
                    end else if (vs_fall) begin
                        resync_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (rd_burst_data_valid) begin
                        beat_q  <= beat_d;
                        wen_q   <= 1'b1;
                        wdata_q <= rd_burst_data;
                    end
                    if (beat_last && frame_end) begin
                        done_q <= 1'b1;
                        if (vs_fall) begin
                            state_q       <= S_ARM;
                            fifo_clearn_q <= 1'b0;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end else if (vs_fall) begin
                        late_q <= 1'b1;
                        if (beat_last) begin
                            state_q       <= S_ARM;
                            fifo_clearn_q <= 1'b0;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (beat_last) begin
                        state_q <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (vs_fall) begin
                        state_q       <= S_ARM;
                        fifo_clearn_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (vs_fall) late_q <= 1'b1;
                    if (rd_burst_data_valid) begin
                        beat_q <= beat_d;
                        if (beat_last) begin
                            state_q       <= S_ARM;
                            fifo_clearn_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Offset never reaches 2^OFFS_W, so concatenation equals base + offset.
    assign addr          = {bank_q, 1'b0, ch_q, offs_q};
    assign rd_addr       = addr;
    assign rd_len        = RD_LEN_W'(BURST_LEN);
    assign mem_ren       = mem_ren_q;
    assign w_fifo_clk    = ddr_clk;
    assign w_fifo_en     = wen_q;
    assign w_fifo_data   = wdata_q;
    assign fifo_clearn   = fifo_clearn_q;
    assign frame_rd_done = done_q;
    assign rd_late       = late_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_rd_frame_ctrl.sv
// ============================================================================
// tb_ddr_rd_frame_ctrl : scoreboard bench for ddr_rd_frame_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr_rd_frame_ctrl;

    localparam int DW = 32;
    localparam int AW = 25;
    localparam logic [AW-1:0] BASE_B1 = 25'h08C0000;  // bank 1, channel 3
    localparam logic [AW-1:0] BASE_B2 = 25'h10C0000;  // bank 2, channel 3
    localparam logic [AW-1:0] BASE_B0 = 25'h00C0000;  // bank 0, channel 3

    logic          ddr_clk = 1'b0;
    logic          ddr_rstn;
    logic          ddr_ready;
    logic          mem_ren;
    logic          mem_ren_valid;
    logic [AW-1:0] rd_addr;
    logic [9:0]    rd_len;
    logic          rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic          w_fifo_clk;
    logic          w_fifo_en;
    logic [DW-1:0] w_fifo_data;
    logic [9:0]    fifo_len;
    logic          fifo_full;
    logic          fifo_clearn;
    logic          bank_load;
    logic [1:0]    bank_sel;
    logic [3:0]    ch_sel;
    logic          frame_wr_done;
    logic          vga_vs;
    logic          frame_rd_done;
    logic          rd_late;
    logic          rd_late_clr;

    ddr_rd_frame_ctrl #(
        .BURST_LEN   (4),
        .FRAME_WORDS (16),
        .FIFO_THRESH (8)
    ) dut (
        .ddr_clk             (ddr_clk),
        .ddr_rstn            (ddr_rstn),
        .ddr_ready           (ddr_ready),
        .mem_ren             (mem_ren),
        .mem_ren_valid       (mem_ren_valid),
        .rd_addr             (rd_addr),
        .rd_len              (rd_len),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .w_fifo_clk          (w_fifo_clk),
        .w_fifo_en           (w_fifo_en),
        .w_fifo_data         (w_fifo_data),
        .fifo_len            (fifo_len),
        .fifo_full           (fifo_full),
        .fifo_clearn         (fifo_clearn),
        .bank_load           (bank_load),
        .bank_sel            (bank_sel),
        .ch_sel              (ch_sel),
        .frame_wr_done       (frame_wr_done),
        .vga_vs              (vga_vs),
        .frame_rd_done       (frame_rd_done),
        .rd_late             (rd_late),
        .rd_late_clr         (rd_late_clr)
    );

    always #5 ddr_clk = ~ddr_clk;

    int vectors     = 0;
    int miscompares = 0;
    int n_wen       = 0;
    int n_done      = 0;
    int n_clr       = 0;
    logic [DW-1:0] seed = 32'hA500_0000;
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes the FIFO or has a request accepted.
    always @(negedge ddr_clk) begin
        if (ddr_rstn === 1'b1) begin
            if (w_fifo_en) begin
                n_wen++;
                if (exp_data.size() == 0) chk("w_fifo_en_unexpected", w_fifo_en, 0);
                else                      chk("w_fifo_data", w_fifo_data, exp_data.pop_front());
            end
            if (mem_ren && mem_ren_valid) begin
                if (exp_addr.size() == 0) chk("request_unexpected", mem_ren, 0);
                else                      chk("rd_addr", rd_addr, exp_addr.pop_front());
            end
            if (frame_rd_done) n_done++;
            if (!fifo_clearn)  n_clr++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge ddr_clk);
            #1;
        end
    endtask

    task automatic wait_mem_ren();
        int n = 0;
        while (mem_ren !== 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("mem_ren_wait", mem_ren, 1);
    endtask

    task automatic accept(input int dly);
        wait_mem_ren();
        cyc(dly);
        mem_ren_valid = 1'b1;
        cyc(1);
        mem_ren_valid = 1'b0;
    endtask

    task automatic beats(input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data       = seed;
            if (push) exp_data.push_back(seed);
            seed = seed + 32'h11;
            cyc(1);
        end
        rd_burst_data_valid = 1'b0;
    endtask

    task automatic vsync_pulse();
        vga_vs = 1'b0;
        cyc(4);
        vga_vs = 1'b1;
    endtask

    task automatic burst(input logic [AW-1:0] addr, input int dly);
        exp_addr.push_back(addr);
        accept(dly);
        beats(4, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wen_snap;

        ddr_rstn = 1'b0; ddr_ready = 1'b1; mem_ren_valid = 1'b0;
        rd_burst_data_valid = 1'b0; rd_burst_data = '0; fifo_len = '0; fifo_full = 1'b0;
        bank_load = 1'b0; bank_sel = 2'd1; ch_sel = 4'd3; frame_wr_done = 1'b0;
        vga_vs = 1'b1; rd_late_clr = 1'b0;
        cyc(3);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_fifo_clearn", fifo_clearn, 1);
        chk("rst_w_fifo_en", w_fifo_en, 0);
        chk("rst_frame_rd_done", frame_rd_done, 0);
        chk("rst_rd_late", rd_late, 0);
        chk("rd_len", rd_len, 4);
        ddr_rstn = 1'b1;
        cyc(2);
        bank_load = 1'b1; cyc(1); bank_load = 1'b0;

        // No frame starts before the first written frame is reported.
        vsync_pulse();
        cyc(6);
        chk("idle_no_first_frame", mem_ren, 0);

        // Nominal frame.
        frame_wr_done = 1'b1; cyc(1); frame_wr_done = 1'b0;
        vsync_pulse();
        for (int b = 0; b < 4; b++) burst(BASE_B1 + AW'(4 * b), 2);
        cyc(6);
        chk("f1_writes", n_wen, 16);
        chk("f1_done", n_done, 1);
        chk("f1_clear", n_clr, 1);
        chk("f1_late", rd_late, 0);
        chk("hold_no_req", mem_ren, 0);

        // Threshold gating, then a mid-burst vsync.
        wen_snap = n_wen;
        fifo_len = 10'd8;
        vsync_pulse();
        cyc(6);
        chk("thresh_block", mem_ren, 0);
        fifo_len = 10'd7;
        cyc(1);
        chk("thresh_release", mem_ren, 1);
        fifo_len = 10'd0;
        burst(BASE_B1, 2);
        exp_addr.push_back(BASE_B1 + AW'(4));
        accept(1);
        beats(2, 1'b1);
        vsync_pulse();
        beats(2, 1'b0);
        chk("resync_late", rd_late, 1);
        exp_addr.push_back(BASE_B1);
        wait_mem_ren();
        chk("resync_writes", n_wen - wen_snap, 6);
        chk("resync_clear", n_clr, 3);

        // Vsync while a request is pending: held until accepted, then drained.
        wen_snap = n_wen;
        vsync_pulse();
        cyc(1);
        chk("pending_hold", mem_ren, 1);
        accept(0);
        beats(4, 1'b0);
        chk("drain_no_writes", n_wen - wen_snap, 0);
        chk("drain_late", rd_late, 1);
        wait_mem_ren();
        chk("drain_clear", n_clr, 4);
        rd_late_clr = 1'b1; cyc(1); rd_late_clr = 1'b0;
        chk("late_clr", rd_late, 0);

        // Bank switch mid-frame takes effect at the next frame.
        for (int b = 0; b < 4; b++) begin
            burst(BASE_B1 + AW'(4 * b), 2);
            if (b == 0) begin
                bank_sel = 2'd2; bank_load = 1'b1; cyc(1); bank_load = 1'b0;
            end
        end
        cyc(4);
        chk("f4_done", n_done, 2);
        chk("f4_late", rd_late, 0);
        vsync_pulse();
        burst(BASE_B2, 0);

        // Reset in the middle of a burst.
        exp_addr.push_back(BASE_B2 + AW'(4));
        accept(1);
        beats(2, 1'b1);
        @(negedge ddr_clk);
        #2;
        ddr_rstn = 1'b0;
        #1;
        chk("arst_mem_ren", mem_ren, 0);
        chk("arst_rd_addr", rd_addr, 0);
        chk("arst_w_fifo_en", w_fifo_en, 0);
        chk("arst_fifo_clearn", fifo_clearn, 1);
        chk("arst_rd_late", rd_late, 0);
        cyc(2);
        ddr_rstn = 1'b1;
        beats(2, 1'b0);
        vsync_pulse();
        cyc(6);
        chk("post_rst_idle", mem_ren, 0);
        frame_wr_done = 1'b1; cyc(1); frame_wr_done = 1'b0;
        vsync_pulse();
        burst(BASE_B0, 0);
        cyc(4);
        chk("left_data", exp_data.size(), 0);
        chk("left_addr", exp_addr.size(), 0);
        chk("final_clear", n_clr, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
